// File: rtl/stream_padder_pkg.sv
// Shared geometry helpers and marker types for the stream padder.
package stream_padder_pkg;

  // Padded extent along one axis.
  function automatic int out_dim(input int img, input int pad);
    return img + 2 * pad;
  endfunction

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Frame/line markers that travel with every output word.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } marks_t;

  // One output beat at the default pixel width.
  localparam int DEFAULT_WL = 32;
  typedef struct packed {
    logic [DEFAULT_WL-1:0] data;
    marks_t                marks;
  } beat_t;

endpackage

// File: rtl/stream_padder_if.sv
// Valid/ready pixel stream; the master side also carries frame markers.
interface stream_padder_if #(parameter int WL = 32);
  import stream_padder_pkg::*;

  logic [WL-1:0] data;
  logic          valid;
  logic          ready;
  marks_t        marks;

  modport master (output data, valid, marks, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/stream_padder_pos_counter.sv
// Raster position counter over the padded frame with region/marker flags.
module padder_pos_counter
  import stream_padder_pkg::*;
#(
  parameter int IMG_W = 3,
  parameter int IMG_H = 3,
  parameter int PAD   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic interior,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam int OW = out_dim(IMG_W, PAD);
  localparam int OH = out_dim(IMG_H, PAD);
  localparam int CW = clog2_min1(OW);
  localparam int RW = clog2_min1(OH);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  // Classify the current position; compared as int so PAD+IMG_W never wraps.
  always_comb begin
    interior = (int'(col) >= PAD) && (int'(col) < PAD + IMG_W) &&
               (int'(row) >= PAD) && (int'(row) < PAD + IMG_H);
    sof      = (col == '0) && (row == '0);
    eol      = (int'(col) == OW - 1);
    eof      = eol && (int'(row) == OH - 1);
  end

  // Step through the padded raster, wrapping column then row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (eol) begin
        col <= '0;
        row <= eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_padder.sv
// Pads a raster pixel stream with a border of a programmable value.
module stream_padder
  import stream_padder_pkg::*;
#(
  parameter int WORDLENGTH = 32,
  parameter int IMG_W      = 3,
  parameter int IMG_H      = 3,
  parameter int PAD        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [WORDLENGTH-1:0] pad_value,
  stream_padder_if.slave        in_bus,
  stream_padder_if.master       out_bus,
  output logic                  busy
);

  logic                  load;
  logic                  fire;
  logic                  interior;
  logic                  pos_sof;
  logic                  pos_eol;
  logic                  pos_eof;
  logic [WORDLENGTH-1:0] pad_lat;
  logic [WORDLENGTH-1:0] pad_cur;
  logic [WORDLENGTH-1:0] data_q;
  logic                  valid_q;
  marks_t                marks_q;

  padder_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PAD   (PAD)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .advance  (fire),
    .interior (interior),
    .sof      (pos_sof),
    .eol      (pos_eol),
    .eof      (pos_eof)
  );

  // Output register may take a new word when empty or being drained.
  assign load         = !valid_q || out_bus.ready;
  assign in_bus.ready = rst_n && !clear && load && interior;
  // A pad slot needs no input; an interior slot needs a valid pixel.
  assign fire         = !clear && load && (!interior || in_bus.valid);
  // The frame's first pad word uses the live value, which is latched there.
  assign pad_cur      = pos_sof ? pad_value : pad_lat;

  // Output stage: load a pixel or pad word, or empty once the held word drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      marks_q <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
      marks_q <= '0;
    end else if (fire) begin
      valid_q <= 1'b1;
      data_q  <= interior ? in_bus.data : pad_cur;
      marks_q <= '{sof: pos_sof, eol: pos_eol, eof: pos_eof};
    end else if (load) begin
      valid_q <= 1'b0;
    end
  end

  // Capture the pad value once per frame at its first slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_lat <= '0;
    end else if (fire && pos_sof) begin
      pad_lat <= pad_value;
    end
  end

  assign out_bus.data  = data_q;
  assign out_bus.valid = valid_q;
  assign out_bus.marks = marks_q;
  assign busy          = valid_q || !pos_sof;

endmodule

// File: tb/tb_stream_padder.sv
// Randomised self-checking bench for stream_padder with a frame-index model.
module tb_stream_padder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        vld = 1'b0;
  logic        ordy = 1'b1;
  logic [31:0] dat = '0;
  logic [31:0] padv = '0;
  int          sel = 0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_padder_if #(.WL(32)) a_in ();
  stream_padder_if #(.WL(32)) a_out ();
  stream_padder_if #(.WL(32)) b_in ();
  stream_padder_if #(.WL(32)) b_out ();
  logic a_busy, b_busy, a_clear, b_clear;

  assign a_in.valid  = (sel == 0) && vld;
  assign a_in.data   = dat;
  assign a_in.marks  = '0;
  assign a_out.ready = (sel == 0) ? ordy : 1'b1;
  assign a_clear     = (sel == 0) && clr;
  assign b_in.valid  = (sel == 1) && vld;
  assign b_in.data   = dat;
  assign b_in.marks  = '0;
  assign b_out.ready = (sel == 1) ? ordy : 1'b1;
  assign b_clear     = (sel == 1) && clr;

  stream_padder #(.WORDLENGTH(32), .IMG_W(3), .IMG_H(3), .PAD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .pad_value(padv),
    .in_bus(a_in), .out_bus(a_out), .busy(a_busy)
  );

  stream_padder #(.WORDLENGTH(32), .IMG_W(4), .IMG_H(2), .PAD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .pad_value(padv),
    .in_bus(b_in), .out_bus(b_out), .busy(b_busy)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Model: flat frame index k, whether a word is held, and the expected word.
  int          mk[2];
  bit          mheld[2];
  logic [31:0] mpad[2];
  logic [31:0] md[2];
  bit          msof[2], meol[2], meof[2];

  task automatic step(int id, int iw, int ih, int p, logic m_rst, logic m_clr,
                      logic m_ordy, logic m_ivld, logic [31:0] m_idat, logic m_irdy);
    int ow = iw + 2 * p;
    int oh = ih + 2 * p;
    int r, c;
    bit inter;
    string pfx = (id == 0) ? "A" : "B";
    if (!m_rst || m_clr) begin
      chk({pfx, "_in_ready_idle"}, m_irdy, 0);
      mheld[id] = 0;
      mk[id] = 0;
      if (!m_rst) mpad[id] = '0;
      return;
    end
    if (mheld[id] && !m_ordy) begin
      chk({pfx, "_in_ready_stall"}, m_irdy, 0);
      return;
    end
    r = mk[id] / ow;
    c = mk[id] % ow;
    inter = (r >= p) && (r < p + ih) && (c >= p) && (c < p + iw);
    chk({pfx, "_in_ready"}, m_irdy, inter);
    if (!inter || m_ivld) begin
      if (mk[id] == 0) mpad[id] = padv;
      md[id]    = inter ? m_idat : mpad[id];
      msof[id]  = (mk[id] == 0);
      meol[id]  = (c == ow - 1);
      meof[id]  = (c == ow - 1) && (r == oh - 1);
      mheld[id] = 1;
      mk[id]    = (mk[id] + 1) % (ow * oh);
    end else begin
      mheld[id] = 0;
    end
  endtask

  task automatic cmp(int id, logic ov, logic [31:0] od, logic s, logic l, logic f, logic bz);
    string pfx = (id == 0) ? "A" : "B";
    chk({pfx, "_out_valid"}, ov, mheld[id]);
    if (mheld[id]) begin
      chk({pfx, "_out_data"}, od, md[id]);
      chk({pfx, "_sof"}, s, msof[id]);
      chk({pfx, "_eol"}, l, meol[id]);
      chk({pfx, "_eof"}, f, meof[id]);
    end
    chk({pfx, "_busy"}, bz, mheld[id] || (mk[id] != 0));
  endtask

  typedef struct {
    logic [31:0] d;
    logic        sof, eol, eof;
    int          cyc;
  } cap_t;
  cap_t cap_a[$];
  cap_t cap_b[$];

  initial forever begin
    @(negedge clk);
    step(0, 3, 3, 1, rst_n, a_clear, a_out.ready, a_in.valid, a_in.data, a_in.ready);
    if (a_out.valid && a_out.ready)
      cap_a.push_back('{a_out.data, a_out.marks.sof, a_out.marks.eol, a_out.marks.eof, cyc});
    @(posedge clk);
    #1;
    cmp(0, a_out.valid, a_out.data, a_out.marks.sof, a_out.marks.eol, a_out.marks.eof, a_busy);
  end

  initial forever begin
    @(negedge clk);
    step(1, 4, 2, 0, rst_n, b_clear, b_out.ready, b_in.valid, b_in.data, b_in.ready);
    if (b_out.valid && b_out.ready)
      cap_b.push_back('{b_out.data, b_out.marks.sof, b_out.marks.eol, b_out.marks.eof, cyc});
    @(posedge clk);
    #1;
    cmp(1, b_out.valid, b_out.data, b_out.marks.sof, b_out.marks.eol, b_out.marks.eof, b_busy);
  end

  // Stimulus source
  logic [31:0] feed_q[$];
  int          vprob = 100;
  int          rmode = 0;
  int          phase = 0;
  int          first_acc = -1;
  bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic drive();
    vld  = (feed_q.size() > 0) && ($urandom_range(99) < vprob);
    dat  = (feed_q.size() > 0) ? feed_q[0] : '0;
    ordy = (rmode != 0) ? pat[phase % 4] : 1'b1;
    phase++;
  endtask

  task automatic run(int maxc, int target);
    int n = 0;
    bit acc;
    while (((sel == 0) ? cap_a.size() : cap_b.size()) < target) begin
      if (n >= maxc) begin
        chk("beat_timeout", (sel == 0) ? cap_a.size() : cap_b.size(), target);
        break;
      end
      @(negedge clk);
      acc = vld && ((sel == 0) ? a_in.ready : b_in.ready);
      if (acc && first_acc < 0) first_acc = cyc;
      @(posedge clk);
      #2;
      if (acc) void'(feed_q.pop_front());
      n++;
      drive();
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2;
    clr = 1'b0;
    cap_a.delete();
    cap_b.delete();
  endtask

  logic [31:0] t1d[25];
  logic [31:0] pend;
  int          cnt, cnt2;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", a_out.valid, 0);
    chk("rst_out_data", a_out.data, 0);
    chk("rst_marks", a_out.marks, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready_b", b_in.ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Basic padded frame, pad 0, inputs 1..9
    padv = '0;
    for (int i = 1; i <= 9; i++) feed_q.push_back(i);
    drive();
    run(200, 25);
    for (int i = 0; i < 25; i++) t1d[i] = cap_a[i].d;
    chk("t1_b0", {cap_a[0].d[30:0], cap_a[0].sof}, 32'h1);
    chk("t1_b6", cap_a[6].d, 32'd1);
    chk("t1_b8", cap_a[8].d, 32'd3);
    chk("t1_b9", {cap_a[9].d[30:0], cap_a[9].eol}, 32'h1);
    chk("t1_b12", cap_a[12].d, 32'd5);
    chk("t1_b18", cap_a[18].d, 32'd9);
    chk("t1_b24", {cap_a[24].d[29:0], cap_a[24].eol, cap_a[24].eof}, 32'h3);
    cnt = 0;
    for (int i = 0; i < 25; i++) if (cap_a[i].eol) cnt++;
    chk("t1_eol_count", cnt, 5);

    // Pad value latched per frame; mid-frame change ignored
    do_clear();
    padv = 32'hDEADBEEF;
    for (int i = 1; i <= 9; i++) feed_q.push_back(i);
    for (int i = 11; i <= 19; i++) feed_q.push_back(i);
    drive();
    run(100, 10);
    padv = '0;
    run(300, 50);
    cnt = 0;
    cnt2 = 0;
    for (int i = 0; i < 25; i++) if (cap_a[i].d == 32'hDEADBEEF) cnt++;
    for (int i = 25; i < 50; i++) if (cap_a[i].d == 32'h0) cnt2++;
    chk("t2_dead_pads", cnt, 16);
    chk("t2_zero_pads_next", cnt2, 16);

    // Backpressure pattern with random input validity
    do_clear();
    feed_q.delete();
    for (int i = 1; i <= 9; i++) feed_q.push_back(i);
    vprob = 60;
    rmode = 1;
    phase = 0;
    drive();
    run(800, 25);
    for (int i = 0; i < 25; i++) chk($sformatf("t3_beat%0d", i), cap_a[i].d, t1d[i]);

    // Two frames back to back without bubbles
    rmode = 0;
    vprob = 100;
    do_clear();
    feed_q.delete();
    for (int i = 1; i <= 18; i++) feed_q.push_back(i);
    drive();
    run(300, 50);
    chk("t4_sof25", cap_a[25].sof, 1);
    chk("t4_span", cap_a[49].cyc - cap_a[0].cyc, 49);
    chk("t4_eof49", cap_a[49].eof, 1);

    // Clear after seven beats; pending input kept for the new frame
    do_clear();
    feed_q.delete();
    padv = 32'h55;
    for (int i = 1; i <= 9; i++) feed_q.push_back(i);
    drive();
    run(100, 7);
    pend = feed_q[0];
    vld = 1'b1;
    dat = pend;
    do_clear();
    feed_q.push_back(32'd101);
    feed_q.push_back(32'd102);
    drive();
    run(100, 7);
    chk("t5_sof", cap_a[0].sof, 1);
    chk("t5_pad", cap_a[0].d, 32'h55);
    chk("t5_pending", cap_a[6].d, pend);

    // Reset in the middle of a frame
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", a_out.valid, 0);
    chk("mrst_out_data", a_out.data, 0);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_in_ready", a_in.ready, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    feed_q.delete();

    // Pass-through with markers (PAD=0, 4x2)
    sel = 1;
    cap_b.delete();
    for (int i = 0; i < 8; i++) feed_q.push_back(32'h100 + i);
    first_acc = -1;
    drive();
    run(100, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t6_beat%0d", i), cap_b[i].d, 32'h100 + i);
    chk("t6_sof0", cap_b[0].sof, 1);
    chk("t6_eol3", cap_b[3].eol, 1);
    chk("t6_eol2", cap_b[2].eol, 0);
    chk("t6_eof3", cap_b[3].eof, 0);
    chk("t6_eof7", {cap_b[7].eol, cap_b[7].eof}, 2'b11);
    chk("t6_latency", cap_b[0].cyc - first_acc, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_padder.md
Name: stream_padder

Overview:
- Streaming successor to the flat-bus image padder.
- Accepts a raster-order pixel stream of an IMG_W x IMG_H frame over a valid/ready handshake.
- Emits the padded (IMG_W+2*PAD) x (IMG_H+2*PAD) frame in raster order, with a programmable pad value and frame/line markers.
- Sits between the pixel source and the convolution window generator. PAD is decoupled from kernel size.

Parameters:
- WORDLENGTH, 32, bits per pixel.
- IMG_W, 3, input frame width in pixels (>=1).
- IMG_H, 3, input frame height in pixels (>=1).
- PAD, 1, pad pixels added on each side (>=0; 0 = pass-through with markers).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: returns to frame start, drops held output.
- pad_value  in  WORDLENGTH  pad pixel value; sampled at each frame start.
- in_data  in  WORDLENGTH  input pixel.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  WORDLENGTH  padded-frame pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_sof  out  1  first pixel of padded frame (qualified by out_valid).
- out_eol  out  1  last pixel of a padded row.
- out_eof  out  1  last pixel of padded frame.
- busy  out  1  frame in progress (position counters not at origin, or output held).

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_sof/eol/eof=0, busy=0, in_ready=0, row/col counters=0, latched pad=0.
- Geometry:
  - OW = IMG_W+2*PAD, OH = IMG_H+2*PAD.
  - Column counter col in [0,OW-1]; row counter row in [0,OH-1]; widths $clog2 of each, minimum 1.
  - Interior when PAD<=row<PAD+IMG_H and PAD<=col<PAD+IMG_W; otherwise pad position.
- Output register:
  - Single registered stage. load = !out_valid || out_ready.
  - Pad position with load: load out_data = latched pad, out_valid=1, advance position. No input needed.
  - Interior position with load: in_ready = 1 (combinational from load and interior). On in_valid, load out_data = in_data, out_valid=1, advance. Without in_valid: out_valid falls to 0 if the held word was consumed; position holds.
  - in_ready=0 at pad positions and whenever load=0.
- Latency: one cycle from accepted input (or pad slot) to out_valid.
- Markers: registered alongside out_data from the position being loaded.
  - out_sof = (row==0 && col==0).
  - out_eol = (col==OW-1).
  - out_eof = eol && row==OH-1.
- Advance: col wraps to 0 at OW-1 and increments row; row wraps to 0 at OH-1. Back-to-back frames continue without a bubble.
- pad_value is latched when a load occurs at (0,0). The latched value is used for the whole frame; changes mid-frame are ignored.
- Backpressure: while out_valid && !out_ready, out_data and markers are held stable, counters frozen, in_ready=0.
- clear (sync, priority over all handshakes):
  - Same cycle: in_ready forced 0.
  - Next edge: counters=0, out_valid=0, markers=0.
  - An input presented in the clear cycle is not accepted.
- Reset mid-frame: immediate return to reset state. The next frame starts at (0,0).
- PAD=0: every position is interior. Behaves as a 1-deep register slice with markers.
- Output word count per frame is exactly OW*OH. Input words consumed per frame are exactly IMG_W*IMG_H.

Decomposition:
- Shared package:
  - Localparams/functions computing OW, OH and counter widths (clog2 with minimum 1).
  - Handshake-beat typedef: data, sof, eol, eof.
- One natural sub-module: padder_pos_counter. Raster row/col counter with advance/clear inputs, producing interior, sof, eol and eof flags. The top level holds the output register and handshake.

Test Plan:
- W=H=3, PAD=1, pad_value=0, inputs 1..9, out_ready=1 -> 25 beats: first row 0,0,0,0,0; row 2 = 0,1,2,3,0; last row zeros. sof on beat 0; eol on beats 4,9,...,24; eof on beat 24.
- Same config, pad_value=32'hDEADBEEF, toggled to 0 mid-frame -> all 16 pad beats carry DEADBEEF. The next frame uses 0.
- out_ready pattern 1,0,0,1 repeating, in_valid random -> output sequence identical to the first test; out_data stable while stalled; in_ready never high while out_valid && !out_ready.
- Two frames back-to-back, continuous valid/ready -> 50 beats with no bubble; sof at beats 0 and 25.
- clear asserted after 7 output beats -> next beat has sof=1 and value pad_value. Input that was pending during clear is not consumed.
- PAD=0, W=4, H=2 -> 8 beats equal to inputs; eol on beats 3 and 7; eof on beat 7; one-cycle latency.
